ccx_rst_seq: RTL and testbench

CCX_RST_SEQ -- requirements
Module: ccx_rst_seq

---
 rtl/ccx_rst_seq.sv | 124 ++++++++++++
 tb/tb_ccx_rst_seq.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/ccx_rst_seq.sv
// CCX reset sequencer: synchronizes arst release, then steps through debug-init and core reset release.
// Also runs edge-armed warm resets and has a scan-enable override that holds everything.
module ccx_rst_seq #(
  parameter int DBG_CYC  = 16,
  parameter int RST_CYC  = 32,
  parameter int WARM_CYC = 8
) (
  input  logic rclk,
  input  logic arst,
  input  logic se,
  input  logic warm_req,
  output logic rst_l_out,
  output logic adbginit_l_out,
  output logic warm_ack,
  output logic seq_busy
);

  typedef enum logic [2:0] {
    SYNC     = 3'd0,
    DBG_WAIT = 3'd1,
    RST_WAIT = 3'd2,
    RUN      = 3'd3,
    WARM     = 3'd4
  } state_t;

  localparam logic [5:0] DBG_LOAD  = 6'(DBG_CYC - 1);
  localparam logic [5:0] RST_LOAD  = 6'(RST_CYC - 1);
  localparam logic [5:0] WARM_LOAD = 6'(WARM_CYC - 1);

  state_t     state, state_nxt;
  logic [5:0] cnt, cnt_nxt;
  logic [1:0] sync_q;
  logic       sync_done;
  logic       arm, arm_nxt;
  logic       rst_q, adbg_q, ack_q, busy_q;
  logic       rst_d, adbg_d, ack_d, busy_d;

  always_ff @(posedge rclk or posedge arst) begin
    if (arst) sync_q <= 2'b00;
    else      sync_q <= {sync_q[0], 1'b1};
  end

  assign sync_done = sync_q[1];

  always_ff @(posedge rclk or posedge arst) begin
    if (arst) begin
      state  <= SYNC;
      cnt    <= 6'd0;
      arm    <= 1'b0;
      rst_q  <= 1'b0;
      adbg_q <= 1'b0;
      ack_q  <= 1'b0;
      busy_q <= 1'b1;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      arm    <= arm_nxt;
      rst_q  <= rst_d;
      adbg_q <= adbg_d;
      ack_q  <= ack_d;
      busy_q <= busy_d;
    end
  end

  // With se high nothing advances, so state, count and arm hold in place.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    arm_nxt   = arm;
    if (!se) begin
      case (state)
        SYNC: begin
          if (sync_done) begin
            cnt_nxt   = DBG_LOAD;
            state_nxt = DBG_WAIT;
          end
        end
        DBG_WAIT: begin
          if (cnt == 6'd0) begin
            cnt_nxt   = RST_LOAD;
            state_nxt = RST_WAIT;
          end else begin
            cnt_nxt = cnt - 6'd1;
          end
        end
        RST_WAIT: begin
          if (cnt == 6'd0) state_nxt = RUN;
          else             cnt_nxt   = cnt - 6'd1;
        end
        RUN: begin
          if (warm_req && arm) begin
            cnt_nxt   = WARM_LOAD;
            state_nxt = WARM;
            arm_nxt   = 1'b0;
          end else if (!warm_req) begin
            arm_nxt = 1'b1;
          end
        end
        WARM: begin
          if (cnt == 6'd0) state_nxt = RUN;
          else             cnt_nxt   = cnt - 6'd1;
        end
        default: begin
          state_nxt = SYNC;
          cnt_nxt   = 6'd0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state and registered, so the pins never see decode glitches.
  always_comb begin
    rst_d  = (state_nxt == RUN);
    adbg_d = (state_nxt == RST_WAIT) || (state_nxt == RUN) || (state_nxt == WARM);
    ack_d  = (state_nxt == WARM) && (cnt_nxt == 6'd0) && !((state == WARM) && (cnt == 6'd0));
    busy_d = (state_nxt != RUN);
  end

  assign rst_l_out      = rst_q | se;
  assign adbginit_l_out = adbg_q | se;
  assign warm_ack       = ack_q;
  assign seq_busy       = busy_q;

endmodule

// File: tb/tb_ccx_rst_seq.sv
// Scoreboard bench for ccx_rst_seq: stimulus queues expected output changes with their cycle,
// and a negedge monitor pops and compares each observed change of {rst_l_out, adbginit_l_out, warm_ack, seq_busy}.
module tb_ccx_rst_seq;

  logic rclk = 1'b0;
  logic arst, se, warm_req;
  logic rst_l_out, adbginit_l_out, warm_ack, seq_busy;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cyc;
    logic [3:0] val;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       exp_item;
  logic [3:0] prev_val = 4'bxxxx;
  logic [3:0] cur_val;
  int         b, w;

  ccx_rst_seq dut (
    .rclk           (rclk),
    .arst           (arst),
    .se             (se),
    .warm_req       (warm_req),
    .rst_l_out      (rst_l_out),
    .adbginit_l_out (adbginit_l_out),
    .warm_ack       (warm_ack),
    .seq_busy       (seq_busy)
  );

  always #5 rclk = ~rclk;

  always @(posedge rclk) cyc <= cyc + 1;

  // A cycle of -1 means the change may occur at any cycle.
  task automatic expect_at(input int c, input logic [3:0] v);
    exp_t e;
    e.cyc = c;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge rclk);
    #2;
  endtask

  // The first rising edge after release counts as cycle 0 of the cold sequence.
  task automatic cold_boot(output int base);
    arst = 1'b0;
    base = cyc + 1;
    expect_at(base + 18, 4'b0101);
    expect_at(base + 50, 4'b1100);
  endtask

  task automatic hit_reset();
    arst = 1'b1;
    expect_at(cyc, 4'b0001);
  endtask

  task automatic warm_start(output int wc);
    warm_req = 1'b1;
    wc = cyc + 1;
    expect_at(wc, 4'b0101);
  endtask

  task automatic warm_done(input int wc);
    expect_at(wc + 7, 4'b0111);
    expect_at(wc + 8, 4'b1100);
  endtask

  always @(negedge rclk) begin
    cur_val = {rst_l_out, adbginit_l_out, warm_ack, seq_busy};
    if (cur_val !== prev_val) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_change cyc=%0d got=%b required=no_change", cyc, cur_val);
      end else begin
        exp_item = exp_q.pop_front();
        if (cur_val !== exp_item.val || (exp_item.cyc >= 0 && cyc != exp_item.cyc))
        begin
          errors++;
          $display("[TB] FAIL output_change got=%b@%0d required=%b@%0d",
                   cur_val, cyc, exp_item.val, exp_item.cyc);
        end
      end
      prev_val = cur_val;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    arst     = 1'b1;
    se       = 1'b0;
    warm_req = 1'b0;
    expect_at(-1, 4'b0001);
    tick(3);

    cold_boot(b);
    tick(60);

    warm_start(w);
    warm_done(w);
    tick(1);
    warm_req = 1'b0;
    tick(15);

    // Held request gives one warm cycle; a second needs a fresh rising level.
    warm_start(w);
    warm_done(w);
    tick(30);
    warm_req = 1'b0;
    tick(3);
    warm_start(w);
    warm_done(w);
    tick(1);
    warm_req = 1'b0;
    tick(15);

    hit_reset();
    tick(2);
    cold_boot(b);
    tick(5);
    warm_req = 1'b1;
    tick(55);
    warm_req = 1'b0;
    tick(3);

    hit_reset();
    tick(2);
    arst = 1'b0;
    b = cyc + 1;
    expect_at(b + 18, 4'b0101);
    tick(24);
    se = 1'b1;
    expect_at(cyc, 4'b1101);
    tick(5);
    se = 1'b0;
    expect_at(cyc, 4'b0101);
    expect_at(b + 55, 4'b1100);
    tick(40);

    warm_start(w);
    tick(1);
    warm_req = 1'b0;
    tick(2);
    hit_reset();
    tick(2);
    cold_boot(b);
    tick(60);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL pending_expectations got=%0d required=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
